one_wire_seq: RTL
=================

ONE_WIRE_SEQ -- requirements
Module: one_wire_seq

Interface
REQ-001 SHALL have parameter MAX_RD, default 9, maximum bytes read per transaction (1..15).
REQ-002 SHALL have parameter CRC_CHECK, default 1, enables Dallas CRC-8 check of read bytes.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  transaction request, one-cycle pulse or level.
REQ-006 SHALL have port rom_cmd  input  8  ROM command byte, e.g. 0xCC Skip ROM.
REQ-007 SHALL have port func_cmd  input  8  function command byte.
REQ-008 SHALL have port rd_len  input  4  number of bytes to read after commands.
REQ-009 SHALL have port busy  output  1  transaction in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-011 SHALL have port err_presence  output  1  no presence pulse detected.
REQ-012 SHALL have port err_crc  output  1  CRC residue nonzero.
REQ-013 SHALL have port rd_data  output  8  last completed read byte.
REQ-014 SHALL have port rd_valid  output  1  one-cycle pulse, rd_data new.
REQ-015 SHALL have port eng_cmd  output  2  bit-engine op: 00 reset/presence, 01 write bit, 10 read bit.
REQ-016 SHALL have port eng_wbit  output  1  bit value for write op.
REQ-017 SHALL have port eng_valid  output  1  op request to bit engine.
REQ-018 SHALL have port eng_ready  input  1  bit engine accepts op.
REQ-019 SHALL have port eng_done  input  1  one-cycle pulse, op finished on bus.
REQ-020 SHALL have port eng_rbit  input  1  sampled bus bit at eng_done; for reset op, 0 = presence.

Function
REQ-021 SHALL implement states IDLE, RST, WROM, WFUNC, READ, FIN.
REQ-022 In IDLE, start=1 SHALL latch rom_cmd, func_cmd, min(rd_len, MAX_RD) and enter RST; busy=1 and eng_valid=1 on next cycle.
REQ-023 start while busy=1 SHALL be ignored; latched operands SHALL not change mid-transaction.
REQ-024 Op handshake: eng_valid held with stable eng_cmd/eng_wbit until eng_ready=1 sampled; eng_valid low the following cycle; next op issued only after eng_done; at most one op outstanding.
REQ-025 eng_done with no op outstanding SHALL be ignored.
REQ-026 RST: one reset op; eng_rbit=1 at eng_done -> set err_presence, go FIN, no further ops; eng_rbit=0 -> WROM.
REQ-027 WROM/WFUNC: 8 write ops each, LSB first, 3-bit bit counter; after 8th eng_done go to next state.
REQ-028 After WFUNC: latched length 0 -> FIN; else READ.
REQ-029 READ: read ops shifting eng_rbit into byte LSB first; after 8th bit, rd_data updated and rd_valid pulsed next cycle; byte counter increments; after last byte -> FIN.
REQ-030 CRC (CRC_CHECK=1, length>=2): init 0x00 at start; per read bit fb=crc[0]^bit, crc=crc>>1, if fb crc^=0x8C; err_crc=1 if final crc!=0x00. Otherwise err_crc=0.
REQ-031 FIN: done=1 for exactly one cycle, busy=0 same cycle, return IDLE; err flags valid at done and held until next accepted start, which clears them.
REQ-032 done SHALL follow the final eng_done by exactly one cycle.

Reset
REQ-033 rst=1 SHALL force IDLE next edge regardless of state, abandoning any outstanding op.
REQ-034 Reset values: busy=0, done=0, err_presence=0, err_crc=0, rd_data=0x00, rd_valid=0, eng_cmd=00, eng_wbit=0, eng_valid=0; counters and CRC cleared.

Verification
REQ-035 No presence: start, reset op answered eng_rbit=1 -> exactly 1 op issued, done with err_presence=1, no rd_valid.
REQ-036 rom_cmd=0xCC, func_cmd=0x44, rd_len=0 -> 17 ops: reset, write bits 0,0,1,1,0,0,1,1, then 0,0,1,0,0,0,1,0; done, errors 0.
REQ-037 rom 0xCC, func 0xBE, rd_len=9, engine returns 50 05 4B 46 7F FF 0C 10 1C -> 9 rd_valid with those bytes, err_crc=0; first byte 51 instead -> err_crc=1.
REQ-038 eng_ready low 5 cycles on a write op -> eng_valid, eng_cmd, eng_wbit stable all 5 cycles; start pulse mid-transaction ignored.
REQ-039 rst=1 during READ byte 3 -> next cycle busy=0, eng_valid=0; later start completes normally.
REQ-040 rd_len=15 with MAX_RD=9 -> exactly 9 bytes read, 72 read ops.

Source files
------------

// File: rtl/one_wire_seq.sv
// 1-Wire transaction sequencer. It runs one reset/presence op, then writes the
// ROM command and the function command, then reads up to MAX_RD bytes. All bus
// timing is handled by an external bit engine through a valid/ready/done handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; error flags from the last run are held
// S_RST   | one reset/presence op outstanding or about to be issued
// S_WROM  | writing the ROM command, LSB first
// S_WFUNC | writing the function command, LSB first
// S_READ  | reading bytes LSB first, with CRC-8 accumulated per bit
// S_FIN   | done pulse for one cycle, then back to S_IDLE
module one_wire_seq #(
  parameter int MAX_RD    = 9,
  parameter bit CRC_CHECK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] rom_cmd,
  input  logic [7:0] func_cmd,
  input  logic [3:0] rd_len,
  output logic       busy,
  output logic       done,
  output logic       err_presence,
  output logic       err_crc,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [1:0] eng_cmd,
  output logic       eng_wbit,
  output logic       eng_valid,
  input  logic       eng_ready,
  input  logic       eng_done,
  input  logic       eng_rbit
);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_WROM, S_WFUNC, S_READ, S_FIN} state_t;

  localparam logic [3:0] MAX_LEN = 4'(MAX_RD);

  state_t     state_q, state_d;
  logic [7:0] rom_q, rom_d, func_q, func_d;
  logic [7:0] shift_q, shift_d, crc_q, crc_d, rd_data_q, rd_data_d;
  logic [3:0] len_q, len_d, byte_q, byte_d;
  logic [2:0] bit_q, bit_d;
  logic       valid_q, valid_d, pend_q, pend_d;
  logic       pres_err_q, pres_err_d, crc_err_q, crc_err_d;
  logic       rd_valid_q, rd_valid_d;

  logic       op_done, last_bit, crc_fb;
  logic [7:0] shift_nx, crc_nx;

  // eng_done only counts while an accepted op is outstanding
  assign op_done  = eng_done & pend_q;
  assign last_bit = (bit_q == 3'd7);
  assign shift_nx = {eng_rbit, shift_q[7:1]};
  assign crc_fb   = crc_q[0] ^ eng_rbit;
  assign crc_nx   = {1'b0, crc_q[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);

  assign busy         = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done         = (state_q == S_FIN);
  assign err_presence = pres_err_q;
  assign err_crc      = crc_err_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign eng_valid    = valid_q;

  // Op encoding follows the state; it only moves on eng_done, so it is stable while valid is held
  always_comb begin
    eng_cmd  = 2'b00;
    eng_wbit = 1'b0;
    case (state_q)
      S_WROM:  begin eng_cmd = 2'b01; eng_wbit = rom_q[bit_q];  end
      S_WFUNC: begin eng_cmd = 2'b01; eng_wbit = func_q[bit_q]; end
      S_READ:  eng_cmd = 2'b10;
      default: ;
    endcase
  end

  // Next-state, handshake and datapath updates
  always_comb begin
    state_d    = state_q;
    rom_d      = rom_q;
    func_d     = func_q;
    len_d      = len_q;
    byte_d     = byte_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    crc_d      = crc_q;
    rd_data_d  = rd_data_q;
    valid_d    = valid_q;
    pend_d     = pend_q;
    pres_err_d = pres_err_q;
    crc_err_d  = crc_err_q;
    rd_valid_d = 1'b0;

    if (valid_q && eng_ready) begin
      valid_d = 1'b0;
      pend_d  = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rom_d      = rom_cmd;
          func_d     = func_cmd;
          len_d      = (rd_len > MAX_LEN) ? MAX_LEN : rd_len;
          byte_d     = 4'd0;
          bit_d      = 3'd0;
          shift_d    = 8'h00;
          crc_d      = 8'h00;
          pres_err_d = 1'b0;
          crc_err_d  = 1'b0;
          valid_d    = 1'b1;
          state_d    = S_RST;
        end
      end
      S_RST: begin
        if (op_done) begin
          pend_d = 1'b0;
          if (eng_rbit) begin
            pres_err_d = 1'b1;
            state_d    = S_FIN;
          end else begin
            valid_d = 1'b1;
            state_d = S_WROM;
          end
        end
      end
      S_WROM: begin
        if (op_done) begin
          pend_d  = 1'b0;
          bit_d   = bit_q + 3'd1;
          valid_d = 1'b1;
          if (last_bit) state_d = S_WFUNC;
        end
      end
      S_WFUNC: begin
        if (op_done) begin
          pend_d = 1'b0;
          bit_d  = bit_q + 3'd1;
          if (last_bit && (len_q == 4'd0)) begin
            state_d = S_FIN;
          end else begin
            valid_d = 1'b1;
            if (last_bit) state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (op_done) begin
          pend_d  = 1'b0;
          bit_d   = bit_q + 3'd1;
          shift_d = shift_nx;
          crc_d   = crc_nx;
          valid_d = 1'b1;
          if (last_bit) begin
            rd_data_d  = shift_nx;
            rd_valid_d = 1'b1;
            byte_d     = byte_q + 4'd1;
            if ((byte_q + 4'd1) == len_q) begin
              valid_d   = 1'b0;
              crc_err_d = CRC_CHECK && (len_q >= 4'd2) && (crc_nx != 8'h00);
              state_d   = S_FIN;
            end
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any outstanding op
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rom_q      <= 8'h00;
      func_q     <= 8'h00;
      len_q      <= 4'd0;
      byte_q     <= 4'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      crc_q      <= 8'h00;
      rd_data_q  <= 8'h00;
      valid_q    <= 1'b0;
      pend_q     <= 1'b0;
      pres_err_q <= 1'b0;
      crc_err_q  <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_q      <= rom_d;
      func_q     <= func_d;
      len_q      <= len_d;
      byte_q     <= byte_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      crc_q      <= crc_d;
      rd_data_q  <= rd_data_d;
      valid_q    <= valid_d;
      pend_q     <= pend_d;
      pres_err_q <= pres_err_d;
      crc_err_q  <= crc_err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule
